// File: rtl/seq_digit_sub.sv
// seq_digit_sub: digit-serial subtractor computing a - b - borrow_in over
// WIDTH bits, DIGIT bits per clock, LSB digit first, with a registered borrow.
// Operands are shifted right one digit per cycle; result digits are shifted
// in from the top, so after NDIG cycles diff holds the full result.
// Optional feature: define SEQ_SUB_OVF_EN to add the signed-overflow output ovf.
module seq_digit_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
`ifdef SEQ_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q;
  logic [WIDTH-1:0]   a_q, b_q, diff_q;
  logic               br_q, bout_q;
  logic [DIGIT-1:0]   a_dig, b_dig, d;
  logic [DIGIT:0]     sub;
  logic               bo, last, accept;
  logic [WIDTH-1:0]   diff_next;
`ifdef SEQ_SUB_OVF_EN
  logic               ovf_q;
`endif

  // Current digit arithmetic: the low digit of the shifting operand registers.
  always_comb begin
    a_dig  = a_q[DIGIT-1:0];
    b_dig  = b_q[DIGIT-1:0];
    sub    = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, br_q};
    d      = sub[DIGIT-1:0];
    bo     = sub[DIGIT];
    last   = (k_q == KW'(NDIG - 1));
    accept = (state_q == IDLE) && in_valid;
  end

  // New result digit enters at the top; older digits move one slot down.
  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign diff_next = d;
    end else begin : g_multi_digit
      assign diff_next = {d, diff_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Next-state logic; in_valid is only looked at while in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture operands on accept, process one digit per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      k_q  <= '0;
      a_q  <= a;
      b_q  <= b;
      br_q <= borrow_in;
    end else if (state_q == RUN) begin
      k_q    <= k_q + KW'(1);
      a_q    <= a_q >> DIGIT;
      b_q    <= b_q >> DIGIT;
      br_q   <= bo;
      diff_q <= diff_next;
      if (last) bout_q <= bo;
    end
  end

`ifdef SEQ_SUB_OVF_EN
  // On the last digit a_dig/b_dig/d carry the operand and result sign bits.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_q <= 1'b0;
    else if (state_q == RUN && last)
      ovf_q <= (a_dig[DIGIT-1] ^ b_dig[DIGIT-1]) & (a_dig[DIGIT-1] ^ d[DIGIT-1]);
  end
  assign ovf = ovf_q;
`endif

  // Handshake outputs decode straight from the state register.
  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q == RUN);
    out_valid  = (state_q == DONE);
    diff       = diff_q;
    borrow_out = bout_q;
  end

endmodule

// File: tb/tb_seq_digit_sub.sv
// Bench for seq_digit_sub (WIDTH=16, DIGIT=4): directed vector table, hand
// sequences for backpressure / reset / simultaneous events, random throughput.
module tb_seq_digit_sub;
  localparam int W = 16;
  localparam int NDIG = 4;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, borrow_in, out_valid, out_ready;
  logic         borrow_out, busy, ovf_s;
  logic [W-1:0] a, b, diff;
`ifdef SEQ_SUB_OVF_EN
  logic         ovf;
  assign ovf_s = ovf;
`else
  assign ovf_s = 1'b0;
`endif

  seq_digit_sub #(.WIDTH(W), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
    .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .busy(busy)
`ifdef SEQ_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait for in_ready, present operands for one edge, then scramble inputs.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                       output int t_acc);
    int n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    a = av; b = bv; borrow_in = bi; in_valid = 1'b1;
    step();
    t_acc = cyc;
    in_valid = 1'b0; a = ~av; b = av ^ bv; borrow_in = ~bi;
  endtask

  // Wait for out_valid; returns cycles since acceptance.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (!busy) chk("busy_in_run", {31'd0, busy}, 1);
      step(); lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [W-1:0] a, b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo, ov;
  } vec_t;

  vec_t vt[10];
  int t_acc, t_prev, lat;
  logic [W-1:0] ra, rb, hd;
  logic         rbi, hbo;
  logic [W:0]   ref_full;

  initial begin
    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vt[5] = '{16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vt[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[9] = '{16'h1000, 16'h0FFF, 1'b0, 16'h0001, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    step(); step();
    chk("rst_diff", {16'd0, diff}, 0);
    chk("rst_bout", {31'd0, borrow_out}, 0);
    chk("rst_ovf", {31'd0, ovf_s}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    step();

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      issue(vt[i].a, vt[i].b, vt[i].bi, t_acc);
      chk("in_ready_low_run", {31'd0, in_ready}, 0);
      wait_done(lat);
      chk($sformatf("latency[%0d]", i), lat, NDIG);
      chk($sformatf("diff[%0d]", i), {16'd0, diff}, {16'd0, vt[i].d});
      chk($sformatf("bout[%0d]", i), {31'd0, borrow_out}, {31'd0, vt[i].bo});
`ifdef SEQ_SUB_OVF_EN
      chk($sformatf("ovf[%0d]", i), {31'd0, ovf_s}, {31'd0, vt[i].ov});
`endif
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("idle_after_done", {31'd0, in_ready}, 1);
    end

    // Backpressure: hold result for 10 cycles, ignore in_valid during DONE.
    issue(16'h0000, 16'h0001, 1'b0, t_acc);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin a = 16'h5555; b = 16'h1111; borrow_in = 1'b0; in_valid = 1'b1; end
      step();
      in_valid = 1'b0;
      chk("bp_valid", {31'd0, out_valid}, 1);
      chk("bp_diff", {16'd0, diff}, 32'hFFFF);
      chk("bp_bout", {31'd0, borrow_out}, 1);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
    end
    // out_ready together with in_valid in DONE: release but do not accept.
    out_ready = 1'b1; in_valid = 1'b1; a = 16'h0009; b = 16'h0002; borrow_in = 1'b0;
    step();
    out_ready = 1'b0;
    chk("simul_in_ready", {31'd0, in_ready}, 1);
    chk("simul_not_busy", {31'd0, busy}, 0);
    chk("simul_no_valid", {31'd0, out_valid}, 0);
    step();
    in_valid = 1'b0;
    chk("next_accept_busy", {31'd0, busy}, 1);
    wait_done(lat);
    chk("next_accept_diff", {16'd0, diff}, 32'h0007);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Reset in the middle of RUN.
    issue(16'hFFFF, 16'h0001, 1'b0, t_acc);
    step(); step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_diff", {16'd0, diff}, 0);
    chk("mid_rst_bout", {31'd0, borrow_out}, 0);
    chk("mid_rst_ovf", {31'd0, ovf_s}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_no_valid", {31'd0, out_valid}, 0);
    end
    issue(16'h0010, 16'h0001, 1'b0, t_acc);
    wait_done(lat);
    chk("post_rst_diff", {16'd0, diff}, 32'h000F);
    chk("post_rst_bout", {31'd0, borrow_out}, 0);
    out_ready = 1'b1; step();

    // Back-to-back random operands with out_ready held high.
    t_prev = -1;
    for (int i = 0; i < 100; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom_range(0, 1));
      ref_full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbi};
      hd = ref_full[W-1:0]; hbo = ref_full[W];
      issue(ra, rb, rbi, t_acc);
      if (t_prev >= 0) chk("ii", t_acc - t_prev, NDIG + 2);
      t_prev = t_acc;
      wait_done(lat);
      chk("rnd_diff", {16'd0, diff}, {16'd0, hd});
      chk("rnd_bout", {31'd0, borrow_out}, {31'd0, hbo});
`ifdef SEQ_SUB_OVF_EN
      chk("rnd_ovf", {31'd0, ovf_s}, {31'd0, (ra[W-1] ^ rb[W-1]) & (ra[W-1] ^ hd[W-1])});
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
